mux_n_1_stream: RTL and testbench
=================================

// Module: mux_n_1_stream
// PURPOSE
//  Registered N-input, WIDTH-bit stream multiplexer with valid/ready handshakes on every port.
//  Generalises the combinational 2:1 8-bit mux to N channels of parametrised width.
//  Adds an output register, backpressure, and two select modes: fixed (external sel) and round-robin.
//  Sits between datapath producers and a single shared consumer (e.g. an adder/register-file write port).
// PARAMETERS
//  WIDTH  8                  data bits per channel (>=1)
//  N      4                  number of input channels (>=2)
//  SELW   $clog2(N)          width of sel/out_ch; must equal $clog2(N)
// PORTS
//  clk       in   1          clock; all state updates on rising edge
//  rst_n     in   1          asynchronous active-low reset
//  in_data   in   N*WIDTH    channel i occupies bits [i*WIDTH +: WIDTH]
//  in_valid  in   N          per-channel valid
//  in_ready  out  N          per-channel ready; at most one bit high in any cycle
//  mode      in   1          0 = fixed select, 1 = round-robin
//  sel       in   SELW       channel index used when mode = 0
//  out_data  out  WIDTH      registered output data
//  out_valid out  1          output register holds a word
//  out_ready in   1          consumer accepts word when out_valid & out_ready
//  out_ch    out  SELW       index of the channel that produced out_data
// BEHAVIOUR
//  Reset (async assert, sync release): out_valid=0, out_data=0, out_ch=0, rr_ptr=N-1.
//    Reset clears any held word, including mid-transfer.
//  load_en = !out_valid | out_ready (combinational). in_ready is 0 for all channels when load_en=0.
//  Fixed mode: in_ready[sel] = load_en and all other bits are 0; in_ready does not depend on in_valid.
//    If sel >= N, in_ready = 0 and no transfer occurs.
//  RR mode: grant the first i with in_valid[i]=1, searching rr_ptr+1, rr_ptr+2, ... mod N.
//    in_ready[grant] = load_en; if no valid, in_ready = 0.
//  Transfer on channel i: in_valid[i] & in_ready[i].
//    Next edge: out_data = chan i, out_ch = i, out_valid = 1.
//    In RR mode, rr_ptr = i; rr_ptr changes only on an RR-mode transfer.
//  No transfer, but out_valid & out_ready: next edge out_valid = 0; out_data/out_ch hold their values.
//  Stalled (out_valid & !out_ready): out_data and out_ch are stable.
//  Consume and load in the same cycle: the new word replaces the old one. Full rate is 1 word/cycle.
//  Latency: input transfer to out_valid is 1 cycle. No combinational path from in_data to out_data.
//  mode/sel may change on any cycle. A change affects only the next grant, never the held word.
//  Switching from RR to fixed mode keeps rr_ptr, so round-robin resumes fairly when re-entered.
//  Fairness: with all N valid and out_ready=1, RR grants 0,1,..,N-1,0,... (after reset).
//  No word is dropped or duplicated: each input transfer produces exactly one output transfer.
// TESTING
//  1. Reset, mode=0, sel=2, in_valid=4'b0100, chan2=8'hA5, out_ready=1
//     -> next cycle out_valid=1, out_data=A5, out_ch=2.
//  2. mode=1, in_valid=4'b1111, out_ready=1 held for 8 cycles
//     -> out_ch sequence 0,1,2,3,0,1,2,3; one word per cycle.
//  3. mode=1, in_valid=4'b1010, out_ready=1 -> out_ch alternates 1,3,1,3.
//     Then drop in_valid[3] -> only channel 1 is granted.
//  4. Backpressure: out_valid=1, out_ready=0 for 5 cycles while inputs are valid
//     -> in_ready=0; out_data and out_ch stable.
//     Then out_ready=1 -> the held word retires and a new word loads in the same edge.
//  5. mode=0, sel=3 with in_valid=4'b0001 -> in_ready=4'b1000 and no output.
//     Then sel=0 -> chan0 is transferred.
//  6. Assert rst_n=0 while out_valid=1 and stalled -> out_valid=0 immediately (async).
//     After release, the RR grant starts at channel 0.
//  Scoreboard in every test: per-channel order is preserved; no loss or duplication.

Source files
------------

// File: rtl/mux_n_1_stream.sv
// Registered N:1 stream multiplexer with valid/ready on every port.
// Grants come from an external select (fixed mode) or a rotating round-robin pointer.
module mux_n_1_stream #(
  parameter int WIDTH = 8,
  parameter int N     = 4,
  parameter int SELW  = $clog2(N)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [N*WIDTH-1:0]   in_data,
  input  logic [N-1:0]         in_valid,
  output logic [N-1:0]         in_ready,
  input  logic                 mode,
  input  logic [SELW-1:0]      sel,
  output logic [WIDTH-1:0]     out_data,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [SELW-1:0]      out_ch
);

  logic             load_en;
  logic [SELW-1:0]  rr_ptr;
  logic [SELW-1:0]  grant;
  logic             grant_ok;
  logic [WIDTH-1:0] grant_data;
  logic             xfer;

  // The output register can take a new word when empty or when its word leaves this cycle.
  assign load_en = !out_valid || out_ready;

  // Round-robin searches upward from the channel after the last RR winner.
  always_comb begin
    int              cand;
    logic [SELW-1:0] cand_idx;
    grant    = '0;
    grant_ok = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (mode) begin
      for (int k = 1; k <= N; k++) begin
        cand     = (int'(rr_ptr) + k) % N;
        cand_idx = SELW'(cand);
        if (!grant_ok && in_valid[cand_idx]) begin
          grant    = cand_idx;
          grant_ok = 1'b1;
        end
      end
    end else if (int'(sel) < N) begin
      grant    = sel;
      grant_ok = 1'b1;
    end
  end

  always_comb begin
    in_ready = '0;
    if (grant_ok && load_en) begin
      in_ready[grant] = 1'b1;
    end
  end

  always_comb begin
    grant_data = '0;
    for (int i = 0; i < N; i++) begin
      if (grant == SELW'(i)) begin
        grant_data = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign xfer = grant_ok && load_en && in_valid[grant];

  // rr_ptr only moves on round-robin transfers so fixed-mode traffic cannot skew fairness.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_ch    <= '0;
      rr_ptr    <= SELW'(N - 1);
    end else if (xfer) begin
      out_valid <= 1'b1;
      out_data  <= grant_data;
      out_ch    <= grant;
      if (mode) begin
        rr_ptr <= grant;
      end
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  a_ready_onehot : assert property (@(posedge clk) disable iff (!rst_n) $onehot0(in_ready));

endmodule

// File: tb/tb_mux_n_1_stream.sv
// Self-checking bench for mux_n_1_stream: directed scenarios plus random traffic,
// compared against a stream-level reference model of grants and the output register.
module tb_mux_n_1_stream;
  localparam int WIDTH = 8;
  localparam int N     = 4;
  localparam int SELW  = 2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic [WIDTH-1:0]   chan [N];
  logic [N*WIDTH-1:0] in_data;
  logic [N-1:0]       in_valid = '0;
  logic [N-1:0]       in_ready;
  logic               mode = 1'b0;
  logic [SELW-1:0]    sel = '0;
  logic [WIDTH-1:0]   out_data;
  logic               out_valid;
  logic               out_ready = 1'b0;
  logic [SELW-1:0]    out_ch;

  int checks = 0;
  int failures = 0;

  // Reference model state: output register contents, last RR winner, traffic counts.
  bit               m_valid;
  logic [WIDTH-1:0] m_data;
  int               m_ch;
  int               m_rr;
  int               in_cnt;
  int               out_cnt;

  for (genvar g = 0; g < N; g++) begin : g_pack
    assign in_data[g*WIDTH +: WIDTH] = chan[g];
  end

  always #5 clk = ~clk;

  mux_n_1_stream #(.WIDTH(WIDTH), .N(N), .SELW(SELW)) dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mode(mode), .sel(sel), .out_data(out_data), .out_valid(out_valid),
    .out_ready(out_ready), .out_ch(out_ch)
  );

  // Expected ready: RR picks the valid channel at the smallest forward distance from the last winner.
  function automatic logic [N-1:0] model_ready();
    int g;
    int best;
    int d;
    g = -1;
    best = N;
    if (m_valid && !out_ready) return '0;
    if (!mode) begin
      if (int'(sel) < N) g = int'(sel);
    end else begin
      for (int i = 0; i < N; i++) begin
        if (in_valid[i]) begin
          d = (i - m_rr - 1 + 2 * N) % N;
          if (d < best) begin
            best = d;
            g = i;
          end
        end
      end
    end
    if (g < 0) return '0;
    return N'(1 << g);
  endfunction

  task automatic model_reset();
    m_valid = 1'b0;
    m_data  = '0;
    m_ch    = 0;
    m_rr    = N - 1;
    in_cnt  = 0;
    out_cnt = 0;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    in_valid = '0;
    out_ready = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Called just after a falling edge; inputs settle before the next rising edge.
  task automatic drive(input logic md, input logic [SELW-1:0] s, input logic [N-1:0] v,
                       input logic ordy);
    mode = md;
    sel = s;
    in_valid = v;
    out_ready = ordy;
    for (int i = 0; i < N; i++) chan[i] = WIDTH'($urandom);
    #1;
  endtask

  task automatic step();
    logic [N-1:0] r;
    int x;
    r = model_ready();
    x = -1;
    for (int i = 0; i < N; i++) if (in_valid[i] && r[i]) x = i;
    if (out_valid === 1'b1 && out_ready === 1'b1) out_cnt++;
    @(posedge clk);
    if (x >= 0) begin
      m_valid = 1'b1;
      m_data = chan[x];
      m_ch = x;
      if (mode) m_rr = x;
      in_cnt++;
    end else if (out_ready) begin
      m_valid = 1'b0;
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL reset_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_data !== '0) begin
      failures++;
      $display("[TB] FAIL reset_data: got %h expected 00", out_data);
    end
    checks++;
    if (out_ch !== '0) begin
      failures++;
      $display("[TB] FAIL reset_ch: got %0d expected 0", out_ch);
    end
    do_reset();
  endtask

  task automatic test_fixed();
    drive(1'b0, 2'd2, 4'b0100, 1'b1);
    chan[2] = 8'hA5;
    #1;
    checks++;
    if (in_ready !== 4'b0100) begin
      failures++;
      $display("[TB] FAIL fixed_ready: got %b expected 0100", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_data !== 8'hA5 || out_ch !== 2'd2) begin
      failures++;
      $display("[TB] FAIL fixed_out: got v=%b d=%h ch=%0d expected v=1 d=a5 ch=2",
               out_valid, out_data, out_ch);
    end
  endtask

  task automatic test_rr_all();
    logic [N-1:0] exp_r;
    do_reset();
    for (int c = 0; c < 8; c++) begin
      drive(1'b1, '0, 4'b1111, 1'b1);
      exp_r = model_ready();
      checks++;
      if (in_ready !== exp_r) begin
        failures++;
        $display("[TB] FAIL rr_all_ready c=%0d: got %b expected %b", c, in_ready, exp_r);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(c % N) || out_data !== m_data) begin
        failures++;
        $display("[TB] FAIL rr_all_out c=%0d: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 c, out_valid, out_ch, out_data, c % N, m_data);
      end
    end
  endtask

  task automatic test_rr_sparse();
    int exp_ch;
    for (int c = 0; c < 7; c++) begin
      drive(1'b1, '0, (c < 4) ? 4'b1010 : 4'b0010, 1'b1);
      exp_ch = (c < 4 && (c % 2) == 1) ? 3 : 1;
      step();
      checks++;
      if (out_valid !== 1'b1 || out_ch !== SELW'(exp_ch) || out_data !== m_data) begin
        failures++;
        $display("[TB] FAIL rr_sparse c=%0d: got v=%b ch=%0d d=%h expected v=1 ch=%0d d=%h",
                 c, out_valid, out_ch, out_data, exp_ch, m_data);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [WIDTH-1:0] held_data;
    logic [SELW-1:0]  held_ch;
    logic [N-1:0]     exp_r;
    int               prev_out;
    drive(1'b1, '0, 4'b1111, 1'b1);
    step();
    held_data = m_data;
    held_ch = SELW'(m_ch);
    for (int c = 0; c < 5; c++) begin
      drive(1'($urandom), SELW'($urandom), N'($urandom_range(1, 15)), 1'b0);
      checks++;
      if (in_ready !== '0) begin
        failures++;
        $display("[TB] FAIL bp_ready c=%0d: got %b expected 0000", c, in_ready);
      end
      step();
      checks++;
      if (out_valid !== 1'b1 || out_data !== held_data || out_ch !== held_ch) begin
        failures++;
        $display("[TB] FAIL bp_hold c=%0d: got v=%b d=%h ch=%0d expected v=1 d=%h ch=%0d",
                 c, out_valid, out_data, out_ch, held_data, held_ch);
      end
    end
    drive(1'b1, '0, 4'b1111, 1'b1);
    exp_r = model_ready();
    checks++;
    if (in_ready !== exp_r || in_ready === '0) begin
      failures++;
      $display("[TB] FAIL bp_release_ready: got %b expected %b", in_ready, exp_r);
    end
    prev_out = out_cnt;
    step();
    checks++;
    if (out_cnt !== prev_out + 1 || out_valid !== 1'b1 || out_data !== m_data ||
        out_ch !== SELW'(m_ch)) begin
      failures++;
      $display("[TB] FAIL bp_release: got retired=%0d v=%b d=%h ch=%0d expected retired=%0d v=1 d=%h ch=%0d",
               out_cnt - prev_out, out_valid, out_data, out_ch, 1, m_data, m_ch);
    end
  endtask

  task automatic test_fixed_sel();
    drive(1'b0, 2'd3, 4'b0001, 1'b1);
    checks++;
    if (in_ready !== 4'b1000) begin
      failures++;
      $display("[TB] FAIL sel3_ready: got %b expected 1000", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b0) begin
      failures++;
      $display("[TB] FAIL sel3_no_output: got v=%b expected v=0", out_valid);
    end
    drive(1'b0, 2'd0, 4'b0001, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL sel0_ready: got %b expected 0001", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== m_data) begin
      failures++;
      $display("[TB] FAIL sel0_out: got v=%b ch=%0d d=%h expected v=1 ch=0 d=%h",
               out_valid, out_ch, out_data, m_data);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] exp_r;
    do_reset();
    for (int c = 0; c < 300; c++) begin
      drive(1'($urandom), SELW'($urandom), N'($urandom), ($urandom % 4) != 0);
      exp_r = model_ready();
      checks++;
      if (in_ready !== exp_r) begin
        failures++;
        $display("[TB] FAIL rand_ready c=%0d: got %b expected %b", c, in_ready, exp_r);
      end
      step();
      checks++;
      if (out_valid !== m_valid || out_data !== m_data || out_ch !== SELW'(m_ch)) begin
        failures++;
        $display("[TB] FAIL rand_out c=%0d: got v=%b d=%h ch=%0d expected v=%b d=%h ch=%0d",
                 c, out_valid, out_data, out_ch, m_valid, m_data, m_ch);
      end
    end
    checks++;
    if (out_cnt + int'(out_valid === 1'b1) !== in_cnt) begin
      failures++;
      $display("[TB] FAIL rand_conservation: got delivered+held=%0d expected accepted=%0d",
               out_cnt + int'(out_valid === 1'b1), in_cnt);
    end
  endtask

  task automatic test_async_reset();
    drive(1'b1, '0, 4'b1111, 1'b1);
    step();
    drive(1'b1, '0, 4'b1111, 1'b0);
    step();
    checks++;
    if (out_valid !== 1'b1) begin
      failures++;
      $display("[TB] FAIL areset_setup: got v=%b expected v=1", out_valid);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if (out_valid !== 1'b0 || out_data !== '0 || out_ch !== '0) begin
      failures++;
      $display("[TB] FAIL areset_immediate: got v=%b d=%h ch=%0d expected v=0 d=00 ch=0",
               out_valid, out_data, out_ch);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1'b1, '0, 4'b1111, 1'b1);
    checks++;
    if (in_ready !== 4'b0001) begin
      failures++;
      $display("[TB] FAIL areset_grant: got %b expected 0001", in_ready);
    end
    step();
    checks++;
    if (out_valid !== 1'b1 || out_ch !== 2'd0 || out_data !== m_data) begin
      failures++;
      $display("[TB] FAIL areset_out: got v=%b ch=%0d d=%h expected v=1 ch=0 d=%h",
               out_valid, out_ch, out_data, m_data);
    end
  endtask

  initial begin
    for (int i = 0; i < N; i++) chan[i] = '0;
    model_reset();
    test_reset();
    test_fixed();
    test_rr_all();
    test_rr_sparse();
    test_backpressure();
    test_fixed_sel();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
